// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage record, constants and parameter checks for the hazard unit.
package pipe_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_DEPTH      = 3;
    localparam int REG_ADDR_MAX   = 8;
    localparam int FWD_REGFILE    = 0;

    // Register fields are stored at the widest supported width so one record type serves every REG_ADDR_W.
    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_MAX-1:0] waddr;
        logic                    reg_write;
        logic                    is_load;
        logic [REG_ADDR_MAX-1:0] rs;
        logic [REG_ADDR_MAX-1:0] rt;
        logic                    uses_rs;
        logic                    uses_rt;
    } stage_t;

    function automatic bit params_legal(int addr_w, int depth, int load_ready);
        return addr_w >= 1 && addr_w <= REG_ADDR_MAX && depth >= 2 && depth <= 8 &&
               load_ready >= 2 && load_ready <= depth;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// fwd_select: per-operand match against older entries, youngest producer wins.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int FWD_W = $clog2(DEPTH)
) (
    input  logic                                ex_valid,
    input  logic                                uses,
    input  logic [REG_ADDR_MAX-1:0]             src,
    input  logic [DEPTH-1:1]                    eff_wr,
    input  logic [DEPTH-1:1][REG_ADDR_MAX-1:0]  waddr,
    output logic [FWD_W-1:0]                    sel
);

    always_comb begin
        sel = FWD_W'(FWD_REGFILE);
        for (int k = DEPTH; k >= 2; k--)
            if (ex_valid && uses && eff_wr[k-1] && waddr[k-1] == src) sel = FWD_W'(k - 1);
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard of in-flight instructions driving stalls, flushes,
// EX forwarding selects and saturating stall/flush counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W       = DEF_REG_ADDR_W,
    parameter int DEPTH            = DEF_DEPTH,
    parameter int LOAD_READY_STAGE = 3,
    parameter int CNT_W            = 16,
    parameter int FWD_W            = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flush_ifid,
    output logic [FWD_W-1:0]      ex_fwd_sel_a,
    output logic [FWD_W-1:0]      ex_fwd_sel_b,
    output logic [DEPTH-1:0]      stage_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    generate
        if (!params_legal(REG_ADDR_W, DEPTH, LOAD_READY_STAGE)) begin : g_bad_params
            $error("pipe_hazard_unit: illegal REG_ADDR_W/DEPTH/LOAD_READY_STAGE");
        end
    endgenerate

    stage_t                               st [DEPTH];
    stage_t                               id_rec;
    logic [DEPTH-1:0]                     eff;
    logic [DEPTH-1:0][REG_ADDR_MAX-1:0]   waddr;
    logic                                 hazard;

    assign id_rec = '{valid: id_valid, waddr: REG_ADDR_MAX'(id_waddr), reg_write: id_reg_write,
                      is_load: id_mem_read, rs: REG_ADDR_MAX'(id_rs), rt: REG_ADDR_MAX'(id_rt),
                      uses_rs: id_uses_rs, uses_rt: id_uses_rt};

    // Entry k = i+1; a load there can still feed the ID instruction in time only if k+1 >= LOAD_READY_STAGE.
    always_comb begin
        hazard      = 1'b0;
        eff         = '0;
        waddr       = '0;
        stage_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eff[i]         = st[i].valid && st[i].reg_write && st[i].waddr != '0;
            waddr[i]       = st[i].waddr;
            stage_valid[i] = st[i].valid;
            if (eff[i] && st[i].is_load && i + 2 < LOAD_READY_STAGE &&
                ((id_uses_rs && st[i].waddr == id_rec.rs) || (id_uses_rt && st[i].waddr == id_rec.rt)))
                hazard = 1'b1;
        end
    end

    assign stall      = id_valid && !redirect && hazard;
    assign flush_ifid = redirect && st[0].valid;

    fwd_select #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_fwd_a (
        .ex_valid (st[0].valid),
        .uses     (st[0].uses_rs),
        .src      (st[0].rs),
        .eff_wr   (eff[DEPTH-1:1]),
        .waddr    (waddr[DEPTH-1:1]),
        .sel      (ex_fwd_sel_a)
    );

    fwd_select #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_fwd_b (
        .ex_valid (st[0].valid),
        .uses     (st[0].uses_rt),
        .src      (st[0].rt),
        .eff_wr   (eff[DEPTH-1:1]),
        .waddr    (waddr[DEPTH-1:1]),
        .sel      (ex_fwd_sel_b)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            st[0] <= (id_valid && !stall && !flush_ifid) ? id_rec : '0;
            for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_ifid && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vector table, hand sequences for reset/saturation/enable,
// and randomized traffic against a queue-based pipeline model.
module tb_pipe_hazard_unit;

    localparam int D   = 3;
    localparam int LRS = 3;

    logic       clk = 1'b0, arst_n = 1'b1;
    logic       enable = 1'b0, id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, redirect = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_waddr = '0;
    logic       stall, flush_ifid, s_stall, s_flush;
    logic [1:0] sel_a, sel_b, s_sel_a, s_sel_b;
    logic [2:0] sv, s_sv;
    logic [15:0] scnt, fcnt;
    logic [1:0] s_scnt, s_fcnt;
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit u_dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .redirect(redirect), .stall(stall), .flush_ifid(flush_ifid),
        .ex_fwd_sel_a(sel_a), .ex_fwd_sel_b(sel_b), .stage_valid(sv),
        .stall_cnt(scnt), .flush_cnt(fcnt)
    );

    pipe_hazard_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_waddr(id_waddr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .redirect(redirect), .stall(s_stall), .flush_ifid(s_flush),
        .ex_fwd_sel_a(s_sel_a), .ex_fwd_sel_b(s_sel_b), .stage_valid(s_sv),
        .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    typedef struct {
        int en, idv, rs, rt, urs, urt, wa, rw, ld, rd;
        int st, fl, sa, sb, sv, sc, fc;
    } vec_t;

    typedef struct {
        bit v;
        int wa;
        bit rw, ld;
        int rs, rt;
        bit urs, urt;
    } rec_t;

    vec_t tbl[18];
    rec_t q[$];
    int   m_sc, m_fc;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int en, idv, rs, rt, urs, urt, wa, rw, ld, rd);
        enable       = en != 0;
        id_valid     = idv != 0;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_uses_rs   = urs != 0;
        id_uses_rt   = urt != 0;
        id_waddr     = 5'(wa);
        id_reg_write = rw != 0;
        id_mem_read  = ld != 0;
        redirect     = rd != 0;
    endtask

    function automatic int cap(int v, int mx);
        return v > mx ? mx : v;
    endfunction

    function automatic bit writes(rec_t r);
        return r.v && r.rw && r.wa != 0;
    endfunction

    // A load at entry k is too young for an ID consumer when k+1 < LRS.
    function automatic bit m_stall(rec_t id, bit rd);
        if (!id.v || rd) return 0;
        for (int k = 1; k <= D; k++)
            if (writes(q[k-1]) && q[k-1].ld && k + 1 < LRS &&
                ((id.urs && q[k-1].wa == id.rs) || (id.urt && q[k-1].wa == id.rt)))
                return 1;
        return 0;
    endfunction

    function automatic int m_fwd(int src, bit use_it);
        if (!q[0].v || !use_it) return 0;
        for (int k = 2; k <= D; k++)
            if (writes(q[k-1]) && q[k-1].wa == src) return k - 1;
        return 0;
    endfunction

    function automatic int m_valid();
        int s = 0;
        for (int k = 0; k < D; k++) s += int'(q[k].v) << k;
        return s;
    endfunction

    task automatic model_reset();
        rec_t z = '{default: 0};
        q.delete();
        for (int k = 0; k < D; k++) q.push_back(z);
        m_sc = 0;
        m_fc = 0;
    endtask

    initial begin
        rec_t r, z;
        bit   e_st, e_fl, rd, en;
        z = '{default: 0};
        //        en idv rs rt urs urt wa rw ld rd | st fl sa sb sv sc fc
        tbl = '{
            '{1, 1, 1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0},
            '{1, 1, 3, 1, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0},
            '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 3, 0, 0},
            '{1, 1, 1, 0, 1, 0,  4, 1, 1, 0,  0, 0, 0, 0, 6, 0, 0},
            '{1, 1, 4, 4, 1, 1,  5, 1, 0, 0,  1, 0, 0, 0, 5, 0, 0},
            '{1, 1, 4, 4, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 2, 1, 0},
            '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 2, 2, 5, 1, 0},
            '{1, 1, 1, 0, 1, 0,  0, 1, 1, 0,  0, 0, 0, 0, 2, 1, 0},
            '{1, 1, 0, 0, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 5, 1, 0},
            '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 3, 1, 0},
            '{1, 1, 1, 0, 1, 0,  7, 1, 1, 0,  0, 0, 0, 0, 6, 1, 0},
            '{1, 1, 7, 2, 1, 1,  8, 1, 0, 1,  0, 1, 0, 0, 5, 1, 0},
            '{1, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0, 2, 1, 1},
            '{1, 1, 1, 0, 1, 0,  9, 1, 1, 0,  0, 0, 0, 0, 4, 1, 1},
            '{0, 1, 9, 9, 1, 1, 10, 1, 0, 0,  1, 0, 0, 0, 1, 1, 1},
            '{0, 1, 9, 9, 1, 1, 10, 1, 0, 0,  1, 0, 0, 0, 1, 1, 1},
            '{1, 1, 9, 9, 1, 1, 10, 1, 0, 0,  1, 0, 0, 0, 1, 1, 1},
            '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 1}
        };

        #2 arst_n = 1'b0;
        #1;
        chk("rst stage_valid", int'(sv), 0);
        chk("rst stall_cnt", int'(scnt), 0);
        chk("rst stall", int'(stall), 0);
        chk("rst fwd_a", int'(sel_a), 0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].en, tbl[i].idv, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                  tbl[i].wa, tbl[i].rw, tbl[i].ld, tbl[i].rd);
            #1;
            chk($sformatf("v%0d stall", i), int'(stall), tbl[i].st);
            chk($sformatf("v%0d flush", i), int'(flush_ifid), tbl[i].fl);
            chk($sformatf("v%0d fwd_a", i), int'(sel_a), tbl[i].sa);
            chk($sformatf("v%0d fwd_b", i), int'(sel_b), tbl[i].sb);
            chk($sformatf("v%0d stage_valid", i), int'(sv), tbl[i].sv);
            chk($sformatf("v%0d stall_cnt", i), int'(scnt), tbl[i].sc);
            chk($sformatf("v%0d flush_cnt", i), int'(fcnt), tbl[i].fc);
            chk($sformatf("v%0d sat stall_cnt", i), int'(s_scnt), cap(tbl[i].sc, 3));
            chk($sformatf("v%0d sat flush_cnt", i), int'(s_fcnt), cap(tbl[i].fc, 3));
        end

        // Fill all three entries, then reset mid-stream with a hazard and redirect on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 2, 3, 1, 1, 1, 1, 0, 0);
        end
        @(negedge clk);
        #1 chk("pre-reset stage_valid", int'(sv), 7);
        arst_n = 1'b0;
        drive(1, 1, 1, 1, 1, 1, 5, 1, 0, 1);
        #1;
        chk("mid-reset stage_valid", int'(sv), 0);
        chk("mid-reset stall_cnt", int'(scnt), 0);
        chk("mid-reset flush_cnt", int'(fcnt), 0);
        chk("mid-reset sat flush_cnt", int'(s_fcnt), 0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        chk("post-release stall", int'(stall), 0);
        chk("post-release flush", int'(flush_ifid), 0);

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 0, 0, p + 1, 1, 1, 0);
            @(negedge clk);
            drive(1, 1, p + 1, p + 1, 1, 1, 10, 1, 0, 0);
            #1 chk($sformatf("pair%0d stall", p), int'(stall), 1);
            @(negedge clk);
            #1 chk($sformatf("pair%0d release", p), int'(stall), 0);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pairs stall_cnt", int'(scnt), 5);
        chk("pairs sat stall_cnt", int'(s_scnt), 3);

        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1, 7, 0, 1, 0, 11, 1, 0, 0);
            #1;
            chk($sformatf("hold%0d stall", i), int'(stall), 1);
            chk($sformatf("hold%0d stall_cnt", i), int'(scnt), 5);
            chk($sformatf("hold%0d sat stall_cnt", i), int'(s_scnt), 3);
        end

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            r.v   = $urandom_range(0, 3) != 0;
            r.rs  = $urandom_range(0, 3);
            r.rt  = $urandom_range(0, 3);
            r.urs = $urandom_range(0, 1) != 0;
            r.urt = $urandom_range(0, 1) != 0;
            r.wa  = $urandom_range(0, 3);
            r.rw  = $urandom_range(0, 3) != 0;
            r.ld  = $urandom_range(0, 1) != 0;
            rd    = $urandom_range(0, 7) == 0;
            en    = $urandom_range(0, 7) != 0;
            drive(int'(en), int'(r.v), r.rs, r.rt, int'(r.urs), int'(r.urt), r.wa,
                  int'(r.rw), int'(r.ld), int'(rd));
            #1;
            e_st = m_stall(r, rd);
            e_fl = rd && q[0].v;
            chk("rnd stall", int'(stall), int'(e_st));
            chk("rnd flush", int'(flush_ifid), int'(e_fl));
            chk("rnd fwd_a", int'(sel_a), m_fwd(r.rs, 1) * 0 + m_fwd(q[0].rs, q[0].urs));
            chk("rnd fwd_b", int'(sel_b), m_fwd(q[0].rt, q[0].urt));
            chk("rnd stage_valid", int'(sv), m_valid());
            chk("rnd stall_cnt", int'(scnt), cap(m_sc, 65535));
            chk("rnd flush_cnt", int'(fcnt), cap(m_fc, 65535));
            chk("rnd sat stall_cnt", int'(s_scnt), cap(m_sc, 3));
            chk("rnd sat flush_cnt", int'(s_fcnt), cap(m_fc, 3));
            if (en) begin
                q.push_front((r.v && !e_st && !e_fl) ? r : z);
                void'(q.pop_back());
                m_sc += int'(e_st);
                m_fc += int'(e_fl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard, forwarding and squash controller for the 5-stage in-order datapath.
- Tracks every instruction in flight from EX to writeback in a shift-register scoreboard of DEPTH entries.
- Computes EX-operand forwarding selects, load-use stalls and IF/ID flushes on taken branch/jump.
- Keeps saturating stall/flush performance counters. Sits beside the pipeline registers and drives their enables/clears.

Parameters:
- REG_ADDR_W, 5, register address width.
- DEPTH, 3, tracked stages after ID (entry 1 = EX, entry DEPTH = WB); legal range 2..8.
- LOAD_READY_STAGE, 3, first entry index at which load data is forwardable; legal range 2..DEPTH.
- CNT_W, 16, width of the performance counters.
- FWD_W, $clog2(DEPTH), width of the forwarding selects.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset.
- enable  in  1  global pipeline advance; the same signal that gates every pipeline register.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  ID source registers.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_waddr  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- redirect  in  1  branch/jump in EX is taken.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush_ifid  out  1  clear IF/ID and squash the ID instruction.
- ex_fwd_sel_a, ex_fwd_sel_b  out  FWD_W  EX operand source: 0 = register file, k-1 = result held in entry k.
- stage_valid  out  DEPTH  valid bit per entry.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset is asynchronous, active-low on arst_n, single clock clk.
- Reset values: all entries invalid, stage_valid=0, stall_cnt=0, flush_cnt=0. Outputs derived from state are therefore stall=0, flush_ifid=0, fwd selects=0.
- Entry record fields: valid, waddr, reg_write, is_load, rs, rt, uses_rs, uses_rt.
- enable=0: no state changes and counters hold. Combinational outputs still track the current state.
- Effective write: valid && reg_write && waddr!=0. Register 0 never matches.
- Load-use stall is asserted combinationally when all of the following hold:
  - id_valid=1 and redirect=0;
  - some entry k has valid, is_load and an effective write;
  - its waddr equals a used ID source;
  - k+1 < LOAD_READY_STAGE.
- With defaults, a load immediately followed by a dependent instruction gives exactly one bubble.
- Forwarding (combinational, for entry 1 only):
  - For each used source of entry 1, select the smallest k in 2..DEPTH with an effective write and a matching waddr.
  - Output k-1, or 0 if no entry matches.
  - Non-load results are forwardable from k>=2; loads only from k>=LOAD_READY_STAGE, which the stall rule guarantees.
  - Entry 1 invalid -> both selects 0.
- Redirect:
  - Honoured only if entry 1 is valid. flush_ifid = redirect && entry1.valid.
  - Redirect overrides stall: stall is forced to 0.
- Advance when enable=1:
  - Entries 2..DEPTH take entries 1..DEPTH-1; entry DEPTH retires.
  - Entry 1 loads the ID record if id_valid && !stall && !flush_ifid; otherwise entry 1 becomes invalid (bubble).
- Counters when enable=1:
  - stall_cnt += stall; flush_cnt += flush_ifid.
  - Both saturate at 2^CNT_W-1 and never wrap.
- The register file is write-first, so same-cycle WB->ID reads need no handling here.
- Reset mid-operation: everything clears immediately. The first cycle after release has no stall or flush regardless of the inputs.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage record typedef;
  - the FWD_REGFILE=0 constant;
  - the default REG_ADDR_W/DEPTH;
  - a function checking LOAD_READY_STAGE legality.
- Sub-module fwd_select: one instance per EX operand. It does the per-operand comparison across entries and the youngest-first priority encode to FWD_W.

Test Plan:
- Reset asserted mid-stream with 3 valid entries -> stage_valid=0, counters=0 immediately; stall=0 and flush_ifid=0 on the first cycle after release.
- ID add r3; next cycle ID sub r5,r3,r1 -> when sub is in EX, ex_fwd_sel_a=1, ex_fwd_sel_b=0; stall never asserted.
- lw r4, then add r5,r4,r4 -> stall=1 for exactly 1 cycle and stall_cnt=1; then add in EX with ex_fwd_sel_a=ex_fwd_sel_b=2.
- Producer writing r0 followed by a consumer of r0 -> selects stay 0 and no stall, even when the producer is a load.
- Taken branch in EX (redirect=1) while ID holds a load-use consumer -> flush_ifid=1, stall=0, entry 1 invalid next cycle, flush_cnt+1.
- CNT_W=2, five consecutive load-use pairs -> stall_cnt reaches 3 and holds. With enable=0 throughout a hazard, the counter is unchanged.
